// File: rtl/sincos_lut_if.sv
// Angle-in / sin-cos-out stream bundle for sincos_lut.
// The master side presents angles and consumes results; the slave side is the lookup.
interface sincos_lut_if #(
   parameter int ROM_DEPTH = 64,
   parameter int ROM_WIDTH = 8,
   parameter int TAG_W     = 4
);
   localparam int ADDRW = $clog2(4 * ROM_DEPTH);
   localparam int OUT_W = ROM_WIDTH + 2;

   logic             in_valid;
   logic             in_ready;
   logic [ADDRW-1:0] in_angle;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_sin;
   logic [OUT_W-1:0] out_cos;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_angle, in_tag, out_ready,
      input  in_ready, out_valid, out_sin, out_cos, out_tag
   );

   modport slave (
      input  in_valid, in_angle, in_tag, out_ready,
      output in_ready, out_valid, out_sin, out_cos, out_tag
   );
endinterface

// File: rtl/sincos_lut.sv
// Pipelined quarter-wave sine/cosine lookup with valid/ready flow control.
// Register stages: capture -> decode (ROM address + flags) -> ROM data ->
// ROM output register -> result. An angle captured at edge N is on the
// outputs after edge N+4. All stages advance together on a single enable.
module sincos_lut #(
   parameter int    ROM_DEPTH = 64,
   parameter int    ROM_WIDTH = 8,
   parameter int    TAG_W     = 4,
   parameter string INIT_FILE = "sine_table.mem"
) (
   input  logic        clk,
   input  logic        rst,
   sincos_lut_if.slave bus
);
   localparam int ADDRW = $clog2(4 * ROM_DEPTH);
   localparam int OFFW  = ADDRW - 2;
   localparam int OUT_W = ROM_WIDTH + 2;

   // The quarter-wave image is generated at elaboration from the same formula
   // that produces INIT_FILE, so the block carries no file dependency.
   localparam int          FRAC = 48;
   localparam logic [63:0] PI_Q = 64'h0003_243F_6A88_85A3;  // pi in Q16.48

   if (ROM_DEPTH < 4 || (ROM_DEPTH & (ROM_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sincos_lut: ROM_DEPTH must be a power of two >= 4");
   end
   if (TAG_W < 1) begin : g_bad_tag
      $error("sincos_lut: TAG_W must be >= 1");
   end
   if (INIT_FILE == "") begin : g_bad_image
      $error("sincos_lut: INIT_FILE must name the reference image");
   end

   // round(sin(k*90/ROM_DEPTH deg) * 2^ROM_WIDTH), saturated, via a Taylor series in Q48
   function automatic logic [ROM_DEPTH*ROM_WIDTH-1:0] build_rom();
      logic [ROM_DEPTH*ROM_WIDTH-1:0] img;
      logic [127:0] x, x2, term, acc, scaled;
      img = '0;
      for (int k = 0; k < ROM_DEPTH; k++) begin
         x    = (128'(k) * 128'(PI_Q)) / 128'(2 * ROM_DEPTH);
         x2   = (x * x) >> FRAC;
         term = x;
         acc  = x;
         for (int n = 1; n <= 13; n++) begin
            term = ((term * x2) >> FRAC) / 128'((2 * n) * (2 * n + 1));
            if (n % 2 == 1) acc = acc - term;
            else            acc = acc + term;
         end
         scaled = ((acc << ROM_WIDTH) + (128'(1) << (FRAC - 1))) >> FRAC;
         if (scaled > 128'((1 << ROM_WIDTH) - 1)) scaled = 128'((1 << ROM_WIDTH) - 1);
         img[k*ROM_WIDTH +: ROM_WIDTH] = scaled[ROM_WIDTH-1:0];
      end
      return img;
   endfunction

   localparam logic [ROM_DEPTH*ROM_WIDTH-1:0] ROM_IMAGE = build_rom();

   typedef struct packed {
      logic negate;
      logic force_one;
   } flags_t;

   typedef struct packed {
      logic [OFFW-1:0] addr;
      flags_t          f;
   } lane_t;

   // Quadrant fold: odd quadrants mirror the offset, the upper half negates.
   function automatic lane_t decode(logic [ADDRW-1:0] a);
      lane_t           l;
      logic [1:0]      q;
      logic [OFFW-1:0] o;
      q = a[ADDRW-1 -: 2];
      o = a[OFFW-1:0];
      l.addr        = q[0] ? OFFW'(ROM_DEPTH - int'(o)) : o;
      l.f.negate    = q[1];
      l.f.force_one = q[0] && (o == '0);
      return l;
   endfunction

   // Two's-complement negate of a non-negative magnitude never yields a -0 pattern.
   function automatic logic [OUT_W-1:0] apply(logic [ROM_WIDTH-1:0] m, flags_t f);
      logic [OUT_W-1:0] mag;
      mag = f.force_one ? (OUT_W'(1) << ROM_WIDTH) : {2'b00, m};
      return f.negate ? -mag : mag;
   endfunction

   logic [ROM_WIDTH-1:0] rom [ROM_DEPTH];
   for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
      assign rom[i] = ROM_IMAGE[i*ROM_WIDTH +: ROM_WIDTH];
   end

   logic                 advance;
   logic                 v0, v1, v2, v3, out_valid_q;
   logic [ADDRW-1:0]     angle0;
   logic [TAG_W-1:0]     tag0, tag1, tag2, tag3, out_tag_q;
   lane_t                sin1, cos1;
   flags_t               fs2, fc2, fs3, fc3;
   logic [ROM_WIDTH-1:0] rom_s2, rom_c2, rom_s3, rom_c3;
   logic [OUT_W-1:0]     out_sin_q, out_cos_q;

   assign advance = !out_valid_q || bus.out_ready;

   // Valid chain and result registers; reset wins over advance.
   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         v0          <= 1'b0;
         v1          <= 1'b0;
         v2          <= 1'b0;
         v3          <= 1'b0;
         out_valid_q <= 1'b0;
         out_sin_q   <= '0;
         out_cos_q   <= '0;
         out_tag_q   <= '0;
      end else if (advance) begin
         v0          <= bus.in_valid;
         v1          <= v0;
         v2          <= v1;
         v3          <= v2;
         out_valid_q <= v3;
         if (v3) begin
            out_sin_q <= apply(rom_s3, fs3);
            out_cos_q <= apply(rom_c3, fc3);
            out_tag_q <= tag3;
         end
      end
   end

   // Datapath registers and the two synchronous ROM read ports, all gated by advance.
   // NOTE: payload and ROM registers carry no reset; the valid chain alone decides what is live.
   always_ff @(posedge clk) begin
      if (advance) begin
         angle0 <= bus.in_angle;
         tag0   <= bus.in_tag;
         sin1   <= decode(angle0);
         cos1   <= decode(angle0 + ADDRW'(ROM_DEPTH));
         tag1   <= tag0;
         rom_s2 <= rom[sin1.addr];
         rom_c2 <= rom[cos1.addr];
         fs2    <= sin1.f;
         fc2    <= cos1.f;
         tag2   <= tag1;
         rom_s3 <= rom_s2;
         rom_c3 <= rom_c2;
         fs3    <= fs2;
         fc3    <= fc2;
         tag3   <= tag2;
      end
   end

   assign bus.in_ready  = advance || rst;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sin   = out_sin_q;
   assign bus.out_cos   = out_cos_q;
   assign bus.out_tag   = out_tag_q;
endmodule

// File: tb/tb_sincos_lut.sv
// Self-checking bench for sincos_lut: directed table, full sweep against a
// real-math model, randomized backpressure, mid-stream reset, and a wide variant.
module tb_sincos_lut;
   localparam real PI = 3.14159265358979323846;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sincos_lut_if #(.ROM_DEPTH(64),  .ROM_WIDTH(8),  .TAG_W(4)) bus   ();
   sincos_lut_if #(.ROM_DEPTH(256), .ROM_WIDTH(12), .TAG_W(4)) bus_v ();

   sincos_lut #(.ROM_DEPTH(64),  .ROM_WIDTH(8),  .TAG_W(4)) u_dut   (.clk(clk), .rst(rst), .bus(bus));
   sincos_lut #(.ROM_DEPTH(256), .ROM_WIDTH(12), .TAG_W(4)) u_dut_v (.clk(clk), .rst(rst), .bus(bus_v));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int actual, input int expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic int rom_ref(int k, int depth, int width);
      real v;
      int  r;
      v = $sin(real'(k) * PI / (2.0 * real'(depth))) * real'(1 << width);
      r = $rtoi(v + 0.5);
      if (r > (1 << width) - 1) r = (1 << width) - 1;
      return r;
   endfunction

   function automatic int lut_ref(int a, int depth, int width);
      int q, o, m;
      q = a / depth;
      o = a % depth;
      if (q == 0 || q == 2) m = rom_ref(o, depth, width);
      else if (o == 0)      m = 1 << width;
      else                  m = rom_ref(depth - o, depth, width);
      return (q >= 2) ? -m : m;
   endfunction

   typedef struct { int s; int c; int tag; } exp_t;
   typedef struct { int angle; int tag; int s; int c; } vec_t;

   exp_t       sb_q[$];
   logic       sb_en = 1'b0;
   logic       stalled_prev = 1'b0;
   logic [9:0] held_sin, held_cos;
   logic [3:0] held_tag;

   // Scoreboard and handshake monitor; handshakes seen here commit at the next rising edge.
   always @(negedge clk) begin
      exp_t e;
      if (sb_en) begin
         check("in_ready rule", int'(bus.in_ready), int'(!(bus.out_valid && !bus.out_ready)));
         if (stalled_prev) begin
            check("stall hold valid", int'(bus.out_valid), 1);
            check("stall hold sin", int'($signed(bus.out_sin)), int'($signed(held_sin)));
            check("stall hold cos", int'($signed(bus.out_cos)), int'($signed(held_cos)));
            check("stall hold tag", int'(bus.out_tag), int'(held_tag));
         end
         if (bus.in_valid && bus.in_ready) begin
            e.s   = lut_ref(int'(bus.in_angle), 64, 8);
            e.c   = lut_ref((int'(bus.in_angle) + 64) % 256, 64, 8);
            e.tag = int'(bus.in_tag);
            sb_q.push_back(e);
         end
         if (bus.out_valid && bus.out_ready) begin
            check("output has pending entry", int'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check($sformatf("sb sin (exp tag %0d)", e.tag), int'($signed(bus.out_sin)), e.s);
               check($sformatf("sb cos (exp tag %0d)", e.tag), int'($signed(bus.out_cos)), e.c);
               check("sb tag", int'(bus.out_tag), e.tag);
            end
         end
         stalled_prev = bus.out_valid && !bus.out_ready;
         held_sin     = bus.out_sin;
         held_cos     = bus.out_cos;
         held_tag     = bus.out_tag;
      end else begin
         stalled_prev = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [8];
      vec_t vvec [3];
      int   idx, guard, stale, early;
      logic acc;

      vecs[0] = '{0,   1, 0,    256};
      vecs[1] = '{64,  2, 256,  0};
      vecs[2] = '{128, 3, 0,    -256};
      vecs[3] = '{192, 4, -256, 0};
      vecs[4] = '{32,  5, 181,  181};
      vecs[5] = '{160, 6, -181, -181};
      vecs[6] = '{255, 7, -6,   255};
      vecs[7] = '{1,   8, 6,    255};
      vvec[0] = '{256, 1, 4096,  0};
      vvec[1] = '{768, 2, -4096, 0};
      vvec[2] = '{128, 3, 2896,  2896};

      bus.in_valid   = 1'b0; bus.in_angle   = '0; bus.in_tag   = '0; bus.out_ready   = 1'b1;
      bus_v.in_valid = 1'b0; bus_v.in_angle = '0; bus_v.in_tag = '0; bus_v.out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset out_valid", int'(bus.out_valid), 0);
      check("reset out_sin", int'(bus.out_sin), 0);
      check("reset out_cos", int'(bus.out_cos), 0);
      check("reset out_tag", int'(bus.out_tag), 0);
      check("reset in_ready", int'(bus.in_ready), 1);
      check("reset variant out_valid", int'(bus_v.out_valid), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post-reset in_ready", int'(bus.in_ready), 1);

      // Directed table, back-to-back, latency 4 edges after accept
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (cyc < 8) begin
            bus.in_valid = 1'b1;
            bus.in_angle = 8'(vecs[cyc].angle);
            bus.in_tag   = 4'(vecs[cyc].tag);
         end else begin
            bus.in_valid = 1'b0;
         end
         @(posedge clk); #1;
         if (cyc < 4) begin
            check($sformatf("latency: out_valid after edge N+%0d", cyc), int'(bus.out_valid), 0);
         end else begin
            check($sformatf("dir valid a=%0d", vecs[cyc-4].angle), int'(bus.out_valid), 1);
            check($sformatf("dir sin a=%0d", vecs[cyc-4].angle), int'($signed(bus.out_sin)), vecs[cyc-4].s);
            check($sformatf("dir cos a=%0d", vecs[cyc-4].angle), int'($signed(bus.out_cos)), vecs[cyc-4].c);
            check($sformatf("dir tag a=%0d", vecs[cyc-4].angle), int'(bus.out_tag), vecs[cyc-4].tag);
         end
      end
      @(posedge clk); #1;
      check("dir drained", int'(bus.out_valid), 0);

      // Exhaustive sweep against the model
      sb_en = 1'b1;
      for (int a = 0; a < 256; a++) begin
         bus.in_valid = 1'b1;
         bus.in_angle = 8'(a);
         bus.in_tag   = 4'(a);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      guard = 0;
      while (sb_q.size() != 0 && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      check("sweep drained", sb_q.size(), 0);

      // Backpressure with randomized out_ready
      idx   = 0;
      guard = 0;
      while (idx < 16 && guard < 1000) begin
         bus.in_valid  = 1'b1;
         bus.in_angle  = 8'(idx);
         bus.in_tag    = 4'(idx);
         bus.out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk); #1;
         if (acc) idx++;
         guard++;
      end
      bus.in_valid = 1'b0;
      check("bp all accepted", idx, 16);
      guard = 0;
      while (sb_q.size() != 0 && guard < 400) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         guard++;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp drained", sb_q.size(), 0);
      sb_en = 1'b0;
      @(posedge clk); #1;
      sb_q.delete();

      // Reset with three samples in flight
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_angle = 8'(10 * (i + 1));
         bus.in_tag   = 4'(i + 1);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("in_ready during reset", int'(bus.in_ready), 1);
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid reset out_valid", int'(bus.out_valid), 0);
      check("mid reset out_sin", int'(bus.out_sin), 0);
      check("mid reset out_cos", int'(bus.out_cos), 0);
      check("mid reset out_tag", int'(bus.out_tag), 0);
      stale = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) stale++;
      end
      check("stale samples after reset", stale, 0);
      bus.in_valid = 1'b1;
      bus.in_angle = 8'd64;
      bus.in_tag   = 4'd9;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      early = int'(bus.out_valid);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         early += int'(bus.out_valid);
      end
      check("post-reset early valid count", early, 0);
      @(posedge clk); #1;
      check("post-reset valid", int'(bus.out_valid), 1);
      check("post-reset sin a=64", int'($signed(bus.out_sin)), 256);
      check("post-reset cos a=64", int'($signed(bus.out_cos)), 0);
      check("post-reset tag", int'(bus.out_tag), 9);

      // Wide variant: ROM_DEPTH=256, ROM_WIDTH=12
      for (int cyc = 0; cyc < 7; cyc++) begin
         if (cyc < 3) begin
            bus_v.in_valid = 1'b1;
            bus_v.in_angle = 10'(vvec[cyc].angle);
            bus_v.in_tag   = 4'(vvec[cyc].tag);
         end else begin
            bus_v.in_valid = 1'b0;
         end
         @(posedge clk); #1;
         if (cyc == 3) begin
            check("variant latency", int'(bus_v.out_valid), 0);
         end else if (cyc >= 4) begin
            check($sformatf("var valid a=%0d", vvec[cyc-4].angle), int'(bus_v.out_valid), 1);
            check($sformatf("var sin a=%0d", vvec[cyc-4].angle), int'($signed(bus_v.out_sin)), vvec[cyc-4].s);
            check($sformatf("var cos a=%0d", vvec[cyc-4].angle), int'($signed(bus_v.out_cos)), vvec[cyc-4].c);
            check($sformatf("var tag a=%0d", vvec[cyc-4].angle), int'(bus_v.out_tag), vvec[cyc-4].tag);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sincos_lut.md
# sincos_lut

Pipelined quarter-wave sine/cosine lookup producing both sin(θ) and cos(θ) per accepted angle, in signed fixed point, with valid/ready flow control and a sideband tag. It replaces the single-output, unregistered-control sine lookup in the sprite-rotation and card-overlay transform path. One quarter-wave ROM image is read through two synchronous read ports. The pipeline has a fixed latency and stalls cleanly under backpressure.

## Interface
- ROM_DEPTH, 64: quarter-wave entries covering 0° to just below 90°; must be a power of two, ≥ 4.
- ROM_WIDTH, 8: ROM entry width, equal to the number of fraction bits.
- TAG_W, 4: sideband tag width carried alongside each sample; must be ≥ 1.
- INIT_FILE, "sine_table.mem": hex ROM image with ROM_DEPTH lines.
- ADDRW, $clog2(4*ROM_DEPTH): angle width; derived, not overridden.
- OUT_W, ROM_WIDTH+2: output width; derived.
- clk  in  1  sole clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  angle presented.
- in_ready  out  1  block accepts the angle this cycle.
- in_angle  in  ADDRW  angle in units of 360°/(4·ROM_DEPTH).
- in_tag  in  TAG_W  opaque tag, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sin  out  OUT_W  signed sin(θ), Q2.ROM_WIDTH.
- out_cos  out  OUT_W  signed cos(θ), Q2.ROM_WIDTH.
- out_tag  out  TAG_W  tag of the returned sample.

## Operation
- ROM entry k = round(sin(k·90°/ROM_DEPTH)·2^ROM_WIDTH), saturated to 2^ROM_WIDTH−1. Entry 0 = 0.
- Fixed-point scaling: +1.0 = 2^ROM_WIDTH, −1.0 = −2^ROM_WIDTH. All results are sign-extended to OUT_W.
- Each lookup of angle a: q = a[ADDRW-1:ADDRW-2], o = a[ADDRW-3:0].
  - q=0: rom[o].
  - q=1: +1.0 if o=0, else rom[ROM_DEPTH−o].
  - q=2: −rom[o].
  - q=3: −1.0 if o=0, else −rom[ROM_DEPTH−o].
  - Negating 0 yields 0; there is never a negative zero or a −0 artefact.
- sin uses a = in_angle. cos uses a = (in_angle + ROM_DEPTH) mod 4·ROM_DEPTH, so wrap-around at 360° is natural.
- Pipeline stages:
  - S0: capture angle, tag and valid; compute both ROM addresses plus per-output {negate, force_one} flags.
  - S1: ROM read.
  - S2: ROM output register.
  - S3: apply force_one and negate; register outputs.
- Flags and tag travel with the data through every stage.
- Global advance = !out_valid || out_ready.
  - When advance is high, all stages shift.
  - When advance is low, all stages, including ROM enable and ROM output-register enable, hold.
- in_ready = advance, combinational. A transfer occurs when in_valid && in_ready.
- A bubble (in_valid=0 while advancing) propagates as valid=0.
- Reset:
  - All valid bits clear; out_valid=0.
  - out_sin, out_cos and out_tag = 0.
  - in_ready=1 during and after reset.
  - Reset mid-stream discards all in-flight samples; none emerge afterwards.

## Timing
- Latency: an angle accepted at edge N appears with out_valid=1 after edge N+4 when no stall occurs.
- Throughput: one sample per cycle while out_ready=1.
- Stall: when out_valid && !out_ready, the outputs are held stable and in_ready=0 in the same cycle. No sample is lost or duplicated.
- Outputs are fully registered; in_ready is the only combinational output path (from out_ready and out_valid).
- Reset takes priority over advance in the same cycle.

## Test plan
Defaults: ROM_DEPTH=64, ROM_WIDTH=8.
- Cardinal angles, streamed back-to-back:
  - angle 0 → sin 0, cos 256.
  - angle 64 → sin 256, cos 0.
  - angle 128 → sin 0, cos −256.
  - angle 192 → sin −256, cos 0.
  - out_valid is first seen 4 cycles after the first accept, with no gaps.
- Mid-quadrant angles:
  - angle 32 → sin 181, cos 181.
  - angle 160 → sin −181, cos −181.
  - angle 255 → sin −6, cos 255 (saturated entry); checks wrap-around of the cos address.
- Exhaustive sweep: all 256 angles, each with tag = angle[3:0]. Outputs must match a reference model bit-exactly, in order, with matching tags.
- Backpressure: stream angles 0..15 with out_ready toggled pseudo-randomly (~50%). Require:
  - no loss or duplication;
  - outputs held stable while stalled;
  - in_ready=0 exactly when out_valid && !out_ready.
- Reset mid-stream: assert rst for 1 cycle with 3 samples in flight. Require:
  - out_valid=0 the cycle after;
  - outputs 0;
  - no stale samples afterwards;
  - the next accepted angle 64 returns sin 256 with 4-cycle latency.
- Parameter variant: ROM_DEPTH=256, ROM_WIDTH=12 with a matching image.
  - angle 256 → sin 4096.
  - angle 768 → sin −4096.
  - angle 128 → sin 2896, cos 2896.
